// File: rtl/pc_update_ras_if.sv
// ============================================================================
// pc_update_ras_if : instruction-result inputs and PC/RAS status outputs
// Rev 1.0
// ============================================================================
`default_nettype none

interface pc_update_ras_if #(
   parameter int ADDR_W = 64,
   parameter int CNT_W  = 4
);
   logic              upd_valid;
   logic              stall;
   logic [3:0]        icode;
   logic              cnd;
   logic [ADDR_W-1:0] valC;
   logic [ADDR_W-1:0] valM;
   logic [ADDR_W-1:0] valP;
   logic [ADDR_W-1:0] pc;
   logic [1:0]        stat;
   logic [ADDR_W-1:0] ras_pred;
   logic              ras_pred_valid;
   logic              ras_mispredict;
   logic              ras_overflow;
   logic [CNT_W-1:0]  ras_count;

   modport master (
      output upd_valid, stall, icode, cnd, valC, valM, valP,
      input  pc, stat, ras_pred, ras_pred_valid, ras_mispredict, ras_overflow, ras_count
   );

   modport slave (
      input  upd_valid, stall, icode, cnd, valC, valM, valP,
      output pc, stat, ras_pred, ras_pred_valid, ras_mispredict, ras_overflow, ras_count
   );
endinterface

`default_nettype wire

// File: rtl/pc_update_ras.sv
// ============================================================================
// pc_update_ras : Y86-64 PC update with RUN/HALT/ERR status and return stack
// Rev 1.0
// ============================================================================
`default_nettype none

module pc_update_ras #(
   parameter int              ADDR_W    = 64,
   parameter logic [ADDR_W-1:0] RESET_PC = '0,
   parameter int              RAS_DEPTH = 8,
   parameter int              CNT_W     = $clog2(RAS_DEPTH) + 1
) (
   input wire             clk,
   input wire             rst_n,
   pc_update_ras_if.slave bus
);

   localparam int PTR_W = $clog2(RAS_DEPTH);

   typedef enum logic [1:0] {
      ST_RUN  = 2'b00,
      ST_HALT = 2'b01,
      ST_ERR  = 2'b10
   } stat_e;

   stat_e             stat_q, stat_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [PTR_W-1:0]  top_q, top_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              misp_q, misp_d;
   logic              ovf_q, ovf_d;
   logic [ADDR_W-1:0] ras_q [RAS_DEPTH];

   logic upd;
   logic push;
   logic full;

   assign upd  = bus.upd_valid & ~bus.stall & (stat_q == ST_RUN);
   assign full = (cnt_q == CNT_W'(RAS_DEPTH));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stat_q <= ST_RUN;
         pc_q   <= RESET_PC;
         top_q  <= '0;
         cnt_q  <= '0;
         misp_q <= 1'b0;
         ovf_q  <= 1'b0;
      end else begin
         stat_q <= stat_d;
         pc_q   <= pc_d;
         top_q  <= top_d;
         cnt_q  <= cnt_d;
         misp_q <= misp_d;
         ovf_q  <= ovf_d;
      end
   end

   // Stack contents carry no reset; validity is tracked by cnt_q alone.
   always_ff @(posedge clk) begin
      if (push) begin
         ras_q[top_d] <= bus.valP;
      end
   end

   always_comb begin
      stat_d = stat_q;
      pc_d   = pc_q;
      top_d  = top_q;
      cnt_d  = cnt_q;
      misp_d = 1'b0;
      ovf_d  = ovf_q;
      push   = 1'b0;
      if (upd) begin
         case (bus.icode)
            4'h0: stat_d = ST_HALT;
            4'h7: pc_d = bus.cnd ? bus.valC : bus.valP;
            4'h8: begin
               pc_d  = bus.valC;
               push  = 1'b1;
               top_d = top_q + PTR_W'(1);
               if (full) begin
                  ovf_d = 1'b1;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
            4'h9: begin
               pc_d = bus.valM;
               if (cnt_q != '0) begin
                  misp_d = (ras_q[top_q] != bus.valM);
                  top_d  = top_q - PTR_W'(1);
                  cnt_d  = cnt_q - CNT_W'(1);
               end else begin
                  misp_d = 1'b1;
               end
            end
            4'hC, 4'hD, 4'hE, 4'hF: stat_d = ST_ERR;
            default: pc_d = bus.valP;
         endcase
      end
   end

   assign bus.pc             = pc_q;
   assign bus.stat           = stat_q;
   assign bus.ras_pred       = ras_q[top_q];
   assign bus.ras_pred_valid = (cnt_q != '0);
   assign bus.ras_mispredict = misp_q;
   assign bus.ras_overflow   = ovf_q;
   assign bus.ras_count      = cnt_q;

endmodule

`default_nettype wire
